// File: rtl/crossing_pkg.sv
// Shared definitions for the request/acknowledge clock-domain crossing.
//   sink_state_t   : receive-side handshake state
//   CROSSING_W     : default data width
//   CROSSING_CNT_W : default transfer-counter width
package crossing_pkg;

  typedef enum logic {IDLE, WAIT_LOW} sink_state_t;

  localparam int CROSSING_W     = 32;
  localparam int CROSSING_CNT_W = 16;

endpackage

// File: rtl/crossing_handshake_sink_if.sv
// Bundle of the sink-side handshake and local dequeue signals.
//   io_req_sync  : request level, already synchronized into the sink clock
//   io_data      : quasi-static source-domain data
//   io_ack       : acknowledge level back to the source synchronizer
//   io_deq_valid / io_deq_ready / io_deq_bits : local valid/ready output
//   io_busy      : handshake open
//   io_count     : words captured since reset
// master: the side that drives request, data and downstream ready.
// slave : the sink endpoint itself.
interface crossing_handshake_sink_if
  import crossing_pkg::*;
#(
  parameter int W     = CROSSING_W,
  parameter int CNT_W = CROSSING_CNT_W
);
  logic             io_req_sync;
  logic [W-1:0]     io_data;
  logic             io_ack;
  logic             io_deq_valid;
  logic             io_deq_ready;
  logic [W-1:0]     io_deq_bits;
  logic             io_busy;
  logic [CNT_W-1:0] io_count;

  modport master (
    output io_req_sync, io_data, io_deq_ready,
    input  io_ack, io_deq_valid, io_deq_bits, io_busy, io_count
  );

  modport slave (
    input  io_req_sync, io_data, io_deq_ready,
    output io_ack, io_deq_valid, io_deq_bits, io_busy, io_count
  );
endinterface

// File: rtl/crossing_hold_reg.sv
// Single-entry holding register (valid + bits).
//   clock, reset : sink clock, asynchronous active-low reset
//   load         : write load_bits and set valid (wins over deq)
//   deq          : consume the held word
//   valid, bits  : registered contents
module crossing_hold_reg
  import crossing_pkg::*;
#(
  parameter int W = CROSSING_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_bits,
  input  logic         deq,
  output logic         valid,
  output logic [W-1:0] bits
);

  // A load in the same cycle as a dequeue keeps valid high with the new
  // word, so back-to-back transfers see no bubble. Bits only change on load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      bits  <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        bits  <= load_bits;
      end else if (deq) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/crossing_handshake_sink.sv
// Receive-side endpoint of the four-phase req/ack clock-domain crossing.
// Captures the quasi-static source word when a synchronized request arrives
// and the holding register can take it, raises ack, and drops ack once the
// request falls. The captured word is offered on a local valid/ready port.
//   clock : sink-domain clock
//   reset : asynchronous, active-low reset
//   io    : handshake bundle (slave view), see crossing_handshake_sink_if
module crossing_handshake_sink
  import crossing_pkg::*;
#(
  parameter int W     = CROSSING_W,
  parameter int CNT_W = CROSSING_CNT_W
) (
  input logic                      clock,
  input logic                      reset,
  crossing_handshake_sink_if.slave io
);

  sink_state_t      state;
  logic             ack_q;
  logic [CNT_W-1:0] count_q;
  logic             hold_valid;
  logic [W-1:0]     hold_bits;
  logic             hold_free;
  logic             capture;
  logic             deq;

  // The register is free if empty or being drained this very cycle; this lets
  // a new word replace a consumed one without a bubble.
  assign deq       = hold_valid && io.io_deq_ready;
  assign hold_free = !hold_valid || io.io_deq_ready;
  assign capture   = (state == IDLE) && io.io_req_sync && hold_free;

  crossing_hold_reg #(.W(W)) u_hold (
    .clock     (clock),
    .reset     (reset),
    .load      (capture),
    .load_bits (io.io_data),
    .deq       (deq),
    .valid     (hold_valid),
    .bits      (hold_bits)
  );

  // Handshake FSM: ack mirrors WAIT_LOW; leaving WAIT_LOW needs req low, so a
  // stalled request in IDLE simply holds ack at 0 and the source waits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state   <= WAIT_LOW;
            ack_q   <= 1'b1;
            count_q <= count_q + 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!io.io_req_sync) begin
            state <= IDLE;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.io_ack       = ack_q;
  assign io.io_deq_valid = hold_valid;
  assign io.io_deq_bits  = hold_bits;
  assign io.io_count     = count_q;
  assign io.io_busy      = (state != IDLE) || ack_q;

`ifndef SYNTHESIS
  // A correct source never re-raises req before seeing ack low.
  req_rise_in_wait_low: assert property (
    @(posedge clock) disable iff (!reset)
      (state == WAIT_LOW) |-> !$rose(io.io_req_sync)
  );
`endif

endmodule

// File: doc/crossing_handshake_sink.md
# crossing_handshake_sink

Receive-side endpoint of the four-phase request/acknowledge clock-domain crossing. It consumes the request level after the 3-flop single-bit synchronizer. It captures the source-domain data bus, which is quasi-static and stable while the request is high. It presents the captured word on a local valid/ready interface and returns an acknowledge level to the source domain through the mirror synchronizer. One word is in flight per handshake, and one holding register decouples the acknowledge from downstream backpressure.

## Interface
- `W`, 32: data width in bits.
- `CNT_W`, 16: width of the transfer counter.
- `clock`  in  1: sink-domain clock.
- `reset`  in  1: asynchronous, active-low reset.
- `io_req_sync`  in  1: request level, already synchronized into the `clock` domain.
- `io_data`  in  W: source-domain data. It is guaranteed stable from before req rises until ack is observed high at the source.
- `io_ack`  out  1: acknowledge level, registered, driven to the source-domain synchronizer.
- `io_deq_valid`  out  1: the holding register contains a word.
- `io_deq_ready`  in  1: the downstream accepts the word.
- `io_deq_bits`  out  W: the captured word.
- `io_busy`  out  1: high while a handshake is open (state ≠ IDLE or ack = 1).
- `io_count`  out  CNT_W: number of words captured since reset.

## Operation
- State machine with two states:
  - IDLE: ack = 0, waiting for a request.
  - WAIT_LOW: ack = 1, waiting for req to drop.
- Capture condition: state = IDLE, `io_req_sync` = 1, and the holding register is free. The register is free when `io_deq_valid` = 0, or when `io_deq_valid` = 1 and `io_deq_ready` = 1 in the same cycle.
- On capture:
  - `io_deq_bits` ← `io_data`.
  - `io_deq_valid` ← 1.
  - `io_ack` ← 1.
  - `io_count` ← count + 1, with modulo-2^CNT_W wrap.
  - state ← WAIT_LOW.
- In IDLE with req = 1 and the register not free: no capture. Ack stays 0, and the source stalls.
- In WAIT_LOW with `io_req_sync` = 0: ack ← 0 and state ← IDLE. This is the only path that returns to IDLE.
- In WAIT_LOW with req = 1: hold.
- Dequeue: when `io_deq_valid` and `io_deq_ready` are both 1, the word is consumed. `io_deq_valid` ← 0 unless a capture occurs in the same cycle, in which case valid stays 1 with the new bits.
- `io_deq_bits` holds its value while valid = 0. It is never updated except on capture.
- `io_data` is sampled only in the capture cycle. No other logic reads it.
- Protocol violation (req rising again while state = WAIT_LOW): this is unreachable under a correct source. No recovery logic; a simulation assertion flags it.

## Timing
- Reset values:
  - `io_ack` = 0
  - `io_deq_valid` = 0
  - `io_deq_bits` = 0
  - `io_count` = 0
  - `io_busy` = 0
  - state = IDLE
- Capture latency: `io_req_sync` high at edge N (conditions met) → `io_deq_valid` and `io_ack` high after edge N, visible in cycle N+1.
- Release latency: `io_req_sync` low at edge M in WAIT_LOW → `io_ack` low in cycle M+1. The earliest next capture is at edge M+1.
- Minimum sink-side cycles per transfer: 2. End-to-end rate is bounded by both synchronizer chains.
- `io_deq_valid` is not combinationally dependent on `io_deq_ready`. There is no combinational path from any input to any output.
- Reset mid-handshake: ack drops immediately (asynchronous), and any held word is lost. The source domain must be reset together with the sink.

## Structure
- Shared package `crossing_pkg`:
  - `typedef enum logic {IDLE, WAIT_LOW} sink_state_t`
  - default width constants `CROSSING_W = 32` and `CROSSING_CNT_W = 16`
- One natural sub-module, `crossing_hold_reg`: a single-entry valid/bits register with load and dequeue ports.
- The FSM, ack register and counter stay in the top module.
- Synchronizers are instantiated outside this block, by the crossing wrapper.

## Test plan
- Single transfer, ready held 1:
  - Stimulus: `io_data` = 0xDEADBEEF, req_sync rises at cycle 5.
  - Response: deq_valid = 1 and bits = 0xDEADBEEF in cycle 6; ack = 1 in cycle 6; count = 1.
  - Then drop req at cycle 9 → ack = 0 in cycle 10.
- Backpressure:
  - Stimulus: ready = 0, two complete handshakes attempted.
  - Response: the first is captured and acked. The second req stays high with ack = 0, valid = 1, and bits unchanged.
  - Ready → 1 for one cycle → the second word is captured in that same cycle; valid stays 1 with the new bits.
- Simultaneous dequeue and capture:
  - Stimulus: valid = 1 and ready = 1 on the same edge as a capture.
  - Response: no valid bubble, bits update, count increments by 1.
- Counter wrap: with `CNT_W` = 4, perform 17 transfers → `io_count` = 1.
- Reset mid-handshake:
  - Stimulus: assert reset while in WAIT_LOW with valid = 1.
  - Response: ack, valid, bits, count and busy go to 0 asynchronously, before the next clock edge.
  - After release with req = 0, the FSM stays in IDLE.
- Random throughput:
  - Stimulus: 1000 words with random req-side gaps and random ready.
  - Response: words are received in order with no loss and no duplication, and `io_count` = 1000 at the end.
